pipe_stage_skid_reg: RTL and testbench

PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

---
 rtl/pipe_stage_skid_reg_pkg.sv | 22 ++
 rtl/pipe_stage_skid_reg_data.sv | 20 ++
 rtl/pipe_stage_skid_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared pipeline definitions: FSM encoding, default geometry, occupancy helper.
package pipe_stage_skid_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CH    = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  // Number of held entries implied by a state.
  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      FULL:    occ_of = 2'd1;
      SKID:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_data.sv
// Multi-channel data register with load enable; all channels move in lockstep.
module pipe_data_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d when load is high; clear on reset.
  always_ff @(posedge clk) begin
    if (!rst)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Two-entry skid pipeline stage: main register drives the output, skid register
// catches the one word accepted while downstream stalls, so in_ready never
// depends combinationally on out_ready.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CH    = DEFAULT_CH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*WIDTH-1:0] out_data,
  output logic [1:0]          occupancy
);

  localparam int DW = CH * WIDTH;

  state_t          state;
  state_t          state_nxt;
  logic            in_fire;
  logic            out_fire;
  logic            main_load;
  logic            skid_load;
  logic [DW-1:0]   main_d;
  logic [DW-1:0]   skid_q;

  // Handshakes are gated by reset so no transfer is reported while it is held.
  assign in_ready  = (state != SKID)  & ~freeze & ~flush & rst;
  assign out_valid = (state != EMPTY) & ~freeze & rst;
  assign in_fire   = in_valid  & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and register load decisions; freeze suppresses both fires.
  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_data;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_nxt = SKID;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (out_fire) begin
          main_load = 1'b1;
          main_d    = skid_q;
          state_nxt = FULL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush)
      state_nxt = EMPTY;
  end

  // State and registered occupancy; reset outranks flush and freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      occupancy <= 2'd0;
    end else begin
      state     <= state_nxt;
      occupancy <= occ_of(state_nxt);
    end
  end

  pipe_data_reg #(.W(DW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (out_data)
  );

  pipe_data_reg #(.W(DW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: queue reference model plus directed scenarios.
module tb_pipe_stage_skid_reg;

  localparam int WIDTH = 32;
  localparam int CH    = 2;
  localparam int DW    = WIDTH * CH;

  logic          clk;
  logic          rst;
  logic          freeze;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int vectors;
  int miscompares;
  bit chk_en;

  logic [DW-1:0] q[$];
  logic          exp_ov;
  logic          exp_ir;

  pipe_stage_skid_reg #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference expectations at mid-cycle, then compare when enabled.
  always @(negedge clk) begin
    exp_ov = (q.size() > 0) && !freeze && rst;
    exp_ir = (q.size() < 2) && !freeze && !flush && rst;
    if (chk_en) begin
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("in_ready",  64'(in_ready),  64'(exp_ir));
      if (exp_ov)
        chk("out_data", 64'(out_data), 64'(q[0]));
    end
  end

  // Reference update: a FIFO of at most two words.
  always @(posedge clk) begin
    if (!rst || flush) begin
      q.delete();
    end else if (!freeze) begin
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_ir)  q.push_back(in_data);
    end
  end

  // One cycle: change inputs after the edge, return at the next falling edge.
  task automatic apply(input logic r, input logic fz, input logic fl,
                       input logic iv, input logic [DW-1:0] d, input logic ordy);
    @(posedge clk);
    #1;
    rst       = r;
    freeze    = fz;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
  endtask

  localparam logic [DW-1:0] WA = 64'hAAAA_0001_5555_0001;
  localparam logic [DW-1:0] WB = 64'hBBBB_0002_6666_0002;

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_en      = 1'b0;
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk_en = 1'b1;

    // Streaming: word k is {ch1 = k+1, ch0 = k}
    for (int k = 1; k <= 10; k++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b1, {32'(k + 1), 32'(k)}, 1'b1);
      if (k >= 2) begin
        chk("stream_data", 64'(out_data), {32'(k), 32'(k - 1)});
        chk("stream_occ",  64'(occupancy), 64'd1);
      end
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("stream_last", 64'(out_data), {32'd11, 32'd10});
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("stream_drained", 64'(occupancy), 64'd0);

    // Backpressure
    apply(1'b1, 1'b0, 1'b0, 1'b1, WA, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b1, WB, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("bp_occ2",     64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready),  64'd0);
    chk("bp_data_a",   64'(out_data),  WA);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("bp_pop_a", 64'(out_data), WA);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("bp_pop_b", 64'(out_data), WB);
    chk("bp_occ1",  64'(occupancy), 64'd1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("bp_occ0",  64'(occupancy), 64'd0);

    // Freeze while in SKID
    apply(1'b1, 1'b0, 1'b0, 1'b1, WA, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b1, WB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b1, '1, 1'b1);
      chk("frz_out_valid", 64'(out_valid), 64'd0);
      chk("frz_in_ready",  64'(in_ready),  64'd0);
      chk("frz_occ",       64'(occupancy), 64'd2);
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("frz_rel_a", 64'(out_data), WA);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("frz_rel_b", 64'(out_data), WB);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("frz_drained", 64'(occupancy), 64'd0);

    // Flush together with freeze while in SKID
    apply(1'b1, 1'b0, 1'b0, 1'b1, WA, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b1, WB, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("fl_pre_occ", 64'(occupancy), 64'd2);
    apply(1'b1, 1'b1, 1'b1, 1'b1, WA, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("fl_occ",       64'(occupancy), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);

    // Randomized stress, mostly handshake traffic with rare freeze/flush/reset
    for (int i = 0; i < 10000; i++) begin
      apply(($urandom_range(0, 499) != 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 63) == 0),
            1'($urandom),
            {$urandom, $urandom},
            1'($urandom));
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("final_drained", 64'(occupancy), 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
